// File: rtl/wb_arbiter_pkg.sv
// Shared types and limits for the writeback arbiter and its round-robin core.
package wb_arbiter_pkg;

  localparam int DataWidth = 32;
  localparam int WbReqMax  = 8;

  typedef logic [4:0] RegFile_t;
  typedef logic [3:0] ExpCode_t;

  // Index width that stays legal for a single-entry vector.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback handshake bundle between the execution-unit controllers and the arbiter.
interface wb_arbiter_if
  import wb_arbiter_pkg::*;
#(
  parameter int REQ  = 4,
  parameter int DATA = DataWidth
) ();

  logic                            flush_;
  logic [REQ-1:0]                  wb_req_;
  RegFile_t [REQ-1:0]              pre_wb_rd;
  logic [REQ-1:0]                  wb_ack_;
  logic [REQ-1:0]                  wb_e_;
  RegFile_t [REQ-1:0]              wb_rd;
  logic [REQ-1:0][DATA-1:0]        wb_data;
  logic [REQ-1:0]                  wb_exp_;
  ExpCode_t [REQ-1:0]              wb_exp_code;
  logic                            wake_e_;
  RegFile_t                        wake_rd;
  logic                            out_e_;
  RegFile_t                        out_rd;
  logic [DATA-1:0]                 out_data;
  logic                            out_exp_;
  ExpCode_t                        out_exp_code;
  logic                            busy;

  modport master (
    output flush_, wb_req_, pre_wb_rd, wb_e_, wb_rd, wb_data, wb_exp_, wb_exp_code,
    input  wb_ack_, wake_e_, wake_rd, out_e_, out_rd, out_data, out_exp_, out_exp_code, busy
  );

  modport slave (
    input  flush_, wb_req_, pre_wb_rd, wb_e_, wb_rd, wb_data, wb_exp_, wb_exp_code,
    output wb_ack_, wake_e_, wake_rd, out_e_, out_rd, out_data, out_exp_, out_exp_code, busy
  );

endinterface

// File: rtl/wb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: lowest active index strictly after `last`, cyclically.
module rr_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter  int REQ = 4,
  localparam int IW  = idx_w(REQ)
) (
  input  logic [REQ-1:0] req,
  input  logic [IW-1:0]  last,
  output logic [REQ-1:0] grant,
  output logic [IW-1:0]  grant_idx,
  output logic           grant_v
);

  always_comb begin
    int i;
    grant     = '0;
    grant_idx = '0;
    grant_v   = 1'b0;
    i         = 0;
    // Scan farthest-first so the nearest active index after `last` wins.
    for (int k = REQ; k >= 1; k--) begin
      i = (int'(last) + k) % REQ;
      if (req[i]) begin
        grant_v   = 1'b1;
        grant_idx = IW'(i);
      end
    end
    if (grant_v) grant = REQ'(1) << grant_idx;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin grant of the single RF/ROB writeback port,
// early wakeup one cycle after grant, registered result one cycle after that.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int REQ  = 4,
  parameter int DATA = DataWidth
) (
  input  logic         clk,
  input  logic         reset,
  wb_arbiter_if.slave  bus
);

  localparam int IW = idx_w(REQ);

  if (REQ < 2 || REQ > WbReqMax) begin : g_req_range
    $error("wb_arbiter: REQ must be within 2..WbReqMax");
  end

  logic [IW-1:0]  last_q;
  logic [IW-1:0]  sel_q;
  logic           dphase_q;
  logic [REQ-1:0] req;
  logic [REQ-1:0] grant;
  logic [IW-1:0]  grant_idx;
  logic           grant_v;
  logic           take;

  // A flush blocks every request, so no grant and no new data phase.
  assign req = ~bus.wb_req_ & {REQ{bus.flush_}};

  rr_arbiter #(.REQ(REQ)) u_rr (
    .req       (req),
    .last      (last_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_v   (grant_v)
  );

  assign bus.wb_ack_ = ~grant;
  assign bus.busy    = (~&bus.wb_req_) | dphase_q | ~bus.out_e_;

  // grant -> data phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q   <= IW'(REQ - 1);
      sel_q    <= '0;
      dphase_q <= 1'b0;
      bus.wake_e_ <= 1'b1;
      bus.wake_rd <= '0;
    end else begin
      if (grant_v) begin
        last_q      <= grant_idx;
        sel_q       <= grant_idx;
        bus.wake_rd <= bus.pre_wb_rd[grant_idx];
      end
      dphase_q    <= grant_v;
      bus.wake_e_ <= ~grant_v;
    end
  end

  assign take = dphase_q & bus.flush_;

  // data phase -> writeback bus; a flush here suppresses the write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_e_       <= 1'b1;
      bus.out_exp_     <= 1'b1;
      bus.out_rd       <= '0;
      bus.out_data     <= '0;
      bus.out_exp_code <= '0;
    end else begin
      bus.out_e_   <= ~(take & ~bus.wb_e_[sel_q]);
      bus.out_exp_ <= ~(take & ~bus.wb_exp_[sel_q]);
      if (take) begin
        bus.out_rd       <= bus.wb_rd[sel_q];
        bus.out_data     <= bus.wb_data[sel_q];
        bus.out_exp_code <= bus.wb_exp_code[sel_q];
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed + randomized bench for wb_arbiter against a cycle-level reference model.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int REQ  = 4;
  localparam int DATA = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_arbiter_if #(.REQ(REQ), .DATA(DATA)) bus ();

  wb_arbiter #(.REQ(REQ), .DATA(DATA)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: last winner, unit whose data phase is pending (-1 none), expected outputs.
  int        m_last;
  int        m_pend;
  bit        m_wake_e;
  RegFile_t  m_wake_rd;
  bit        m_out_e;
  bit        m_out_exp;
  RegFile_t  m_out_rd;
  logic [DATA-1:0] m_out_data;
  ExpCode_t  m_out_code;
  int        dut_hist[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last = REQ - 1; m_pend = -1;
    m_wake_e = 1'b1; m_wake_rd = '0;
    m_out_e = 1'b1; m_out_exp = 1'b1; m_out_rd = '0; m_out_data = '0; m_out_code = '0;
  endtask

  function automatic int model_grant(input logic [REQ-1:0] req_n, input logic fl_n);
    if (!fl_n) return -1;
    for (int k = 1; k <= REQ; k++)
      if (!req_n[(m_last + k) % REQ]) return (m_last + k) % REQ;
    return -1;
  endfunction

  task automatic idle_inputs();
    bus.flush_ = 1'b1; bus.wb_req_ = '1; bus.wb_e_ = '1; bus.wb_exp_ = '1;
    for (int i = 0; i < REQ; i++) begin
      bus.pre_wb_rd[i] = '0; bus.wb_rd[i] = '0; bus.wb_data[i] = '0; bus.wb_exp_code[i] = '0;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ack"},     bus.wb_ack_, {REQ{1'b1}});
    chk({tag, "_wake_e"},  bus.wake_e_, 1);
    chk({tag, "_wake_rd"}, bus.wake_rd, 0);
    chk({tag, "_out_e"},   bus.out_e_, 1);
    chk({tag, "_out_exp"}, bus.out_exp_, 1);
    chk({tag, "_out_rd"},  bus.out_rd, 0);
    chk({tag, "_out_data"}, bus.out_data, 0);
    chk({tag, "_out_code"}, bus.out_exp_code, 0);
  endtask

  // One clock: comb checks before the edge, model advance, registered checks after it.
  task automatic cycle(output int g);
    logic [REQ-1:0] exp_ack;
    int dg;
    @(negedge clk);
    g = model_grant(bus.wb_req_, bus.flush_);
    exp_ack = '1;
    if (g >= 0) exp_ack[g] = 1'b0;
    dg = -1;
    for (int i = 0; i < REQ; i++) if (!bus.wb_ack_[i]) dg = i;
    dut_hist.push_back(dg);
    chk("ack", bus.wb_ack_, exp_ack);
    chk("busy", bus.busy, ((~&bus.wb_req_) || m_pend >= 0 || !m_out_e) ? 1 : 0);
    if (bus.flush_ && m_pend >= 0) begin
      m_out_e    = bus.wb_e_[m_pend];
      m_out_exp  = bus.wb_exp_[m_pend];
      m_out_rd   = bus.wb_rd[m_pend];
      m_out_data = bus.wb_data[m_pend];
      m_out_code = bus.wb_exp_code[m_pend];
    end else begin
      m_out_e   = 1'b1;
      m_out_exp = 1'b1;
    end
    m_wake_e = (g < 0);
    if (g >= 0) begin
      m_wake_rd = bus.pre_wb_rd[g];
      m_last    = g;
    end
    m_pend = g;
    @(posedge clk);
    #1;
    chk("wake_e", bus.wake_e_, m_wake_e);
    chk("wake_rd", bus.wake_rd, m_wake_rd);
    chk("out_e", bus.out_e_, m_out_e);
    chk("out_exp", bus.out_exp_, m_out_exp);
    chk("out_rd", bus.out_rd, m_out_rd);
    chk("out_data", bus.out_data, m_out_data);
    chk("out_code", bus.out_exp_code, m_out_code);
  endtask

  task automatic sync_reset_pulse();
    reset = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int g;
    logic [REQ-1:0] want;
    reset = 1'b1;
    idle_inputs();
    model_reset();
    #12;
    chk_reset_outputs("rst");
    chk("rst_busy", bus.busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single request from unit 2, result 0xDEADBEEF; other lanes carry noise.
    bus.wb_req_[2] = 1'b0; bus.pre_wb_rd[2] = 5'd5;
    cycle(g);
    chk("t1_ack_grant", dut_hist[$], 2);
    chk("t1_wake_e", bus.wake_e_, 0);
    chk("t1_wake_rd", bus.wake_rd, 5);
    bus.wb_req_[2] = 1'b1;
    bus.wb_e_ = 4'b1010; bus.wb_rd[2] = 5'd5; bus.wb_data[2] = 32'hDEADBEEF;
    bus.wb_data[0] = 32'h1111_1111; bus.wb_rd[0] = 5'd7;
    cycle(g);
    chk("t1_out_e", bus.out_e_, 0);
    chk("t1_out_data", bus.out_data, 32'hDEADBEEF);
    chk("t1_out_rd", bus.out_rd, 5);
    idle_inputs();
    cycle(g);
    chk("t1_out_e_done", bus.out_e_, 1);

    // All four units request continuously from reset.
    sync_reset_pulse();
    bus.wb_req_ = '0; bus.wb_e_ = '0;
    for (int i = 0; i < REQ; i++) begin
      bus.pre_wb_rd[i] = RegFile_t'(i + 10);
      bus.wb_rd[i]     = RegFile_t'(i + 10);
      bus.wb_data[i]   = 32'hA000_0000 + i;
    end
    dut_hist.delete();
    for (int k = 0; k < 8; k++) begin
      cycle(g);
      chk("rr_order", dut_hist[k], k % REQ);
      if (k >= 1) chk("rr_out_e", bus.out_e_, 0);
    end
    idle_inputs();
    cycle(g); cycle(g);

    // Units 1 and 3 with last winner 1: expect 3 then 1.
    bus.wb_req_[1] = 1'b0;
    cycle(g);
    bus.wb_req_ = '1;
    cycle(g);
    bus.wb_req_[1] = 1'b0; bus.wb_req_[3] = 1'b0;
    dut_hist.delete();
    cycle(g);
    chk("pair_first", dut_hist[0], 3);
    bus.wb_req_[3] = 1'b1;
    cycle(g);
    chk("pair_second", dut_hist[1], 1);
    bus.wb_req_ = '1;
    cycle(g); cycle(g);

    // Flush in the data phase after a grant to unit 0.
    bus.wb_req_[0] = 1'b0; bus.pre_wb_rd[0] = 5'd3;
    cycle(g);
    chk("fl_grant0", g, 0);
    chk("fl_wake_e", bus.wake_e_, 0);
    bus.wb_req_ = '1; bus.flush_ = 1'b0; bus.wb_e_[0] = 1'b0; bus.wb_data[0] = 32'h5555;
    cycle(g);
    chk("fl_out_e", bus.out_e_, 1);
    // Flush in the grant cycle: no ack, no wakeup, pointer kept so unit 1 wins next.
    bus.wb_req_[0] = 1'b0; bus.wb_req_[1] = 1'b0;
    cycle(g);
    chk("flg_wake_e", bus.wake_e_, 1);
    chk("flg_ack", dut_hist[$], -1);
    bus.flush_ = 1'b1;
    cycle(g);
    chk("flg_next", dut_hist[$], 1);
    bus.wb_req_[1] = 1'b1;
    cycle(g);
    chk("flg_then0", dut_hist[$], 0);
    idle_inputs();
    cycle(g); cycle(g);

    // Exception passes through with rd and data.
    bus.wb_req_[1] = 1'b0; bus.pre_wb_rd[1] = 5'd9;
    cycle(g);
    bus.wb_req_ = '1;
    bus.wb_e_[1] = 1'b0; bus.wb_exp_[1] = 1'b0; bus.wb_exp_code[1] = 4'h2;
    bus.wb_rd[1] = 5'd9; bus.wb_data[1] = 32'h0BAD_F00D;
    cycle(g);
    chk("exp_flag", bus.out_exp_, 0);
    chk("exp_code", bus.out_exp_code, 4'h2);
    chk("exp_rd", bus.out_rd, 9);
    chk("exp_data", bus.out_data, 32'h0BAD_F00D);
    idle_inputs();
    cycle(g);

    // Randomized traffic: units hold requests until acked, random flushes, noisy lanes.
    want = '0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < REQ; i++) begin
        if (!want[i] && $urandom_range(0, 2) == 0) want[i] = 1'b1;
        if (!want[i] || $urandom_range(0, 3) == 0) bus.pre_wb_rd[i] = RegFile_t'($urandom);
        bus.wb_rd[i]       = RegFile_t'($urandom);
        bus.wb_data[i]     = $urandom;
        bus.wb_exp_code[i] = ExpCode_t'($urandom);
      end
      bus.wb_req_ = ~want;
      bus.wb_e_   = REQ'($urandom) | REQ'($urandom);
      bus.wb_exp_ = REQ'($urandom) | REQ'($urandom);
      bus.flush_  = ($urandom_range(0, 9) != 0);
      cycle(g);
      if (g >= 0) want[g] = 1'b0;
    end
    idle_inputs();
    cycle(g); cycle(g);

    // Reset during a data phase: asynchronous return, no out_e_ pulse, unit 0 first after.
    bus.wb_req_[2] = 1'b0; bus.pre_wb_rd[2] = 5'd17;
    cycle(g);
    bus.wb_req_ = '1; bus.wb_e_[2] = 1'b0; bus.wb_data[2] = 32'hCAFE_0001; bus.wb_rd[2] = 5'd17;
    #2;
    reset = 1'b1;
    #1;
    chk_reset_outputs("arst");
    @(posedge clk); #1;
    chk("arst_no_pulse", bus.out_e_, 1);
    idle_inputs();
    reset = 1'b0;
    model_reset();
    bus.wb_req_ = '0;
    dut_hist.delete();
    cycle(g);
    chk("arst_first", dut_hist[0], 0);
    idle_inputs();
    cycle(g); cycle(g);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
